multicycle_control: RTL and testbench

Multicycle control FSM that drives the control inputs of the processor datapath: PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, ALU_Bin_sel, ALU_func and MEM_WrEn.
- Consumes the fetched instruction word and the ALU Zero flag.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH, one state per clock.
- Replaces the single-cycle combinational decode so the datapath runs one instruction over 3–5 cycles.

---
 rtl/ctrl_pkg.sv | 70 +++++++
 rtl/ctrl_opdecode.sv | 26 ++
 rtl/multicycle_control.sv | 154 +++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control FSM: state encoding,
// opcode values, ALU function codes and the opcode class bundle.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_BRANCH,
        S_WB_LITE,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    // Table of every legal opcode; the IDX_* constants name its slots.
    localparam int NUM_OPS = 10;
    localparam int IDX_RTYPE = 0;
    localparam int IDX_LI    = 1;
    localparam int IDX_ADDI  = 2;
    localparam int IDX_ANDI  = 3;
    localparam int IDX_ORI   = 4;
    localparam int IDX_B     = 5;
    localparam int IDX_BEQ   = 6;
    localparam int IDX_BNE   = 7;
    localparam int IDX_LW    = 8;
    localparam int IDX_SW    = 9;

    localparam logic [NUM_OPS-1:0][5:0] OP_TABLE = {
        OP_SW, OP_LW, OP_BNE, OP_BEQ, OP_B,
        OP_ORI, OP_ANDI, OP_ADDI, OP_LI, OP_RTYPE
    };

    typedef struct packed {
        logic rtype;
        logic imm;
        logic load;
        logic store;
        logic cbranch;
        logic ubranch;
        logic illegal;
    } op_class_t;

    // ALU function for instructions that take the immediate as operand B.
    function automatic logic [3:0] imm_alu_func(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode-to-class decode shared by the FSM next-state and
// output logic.
module ctrl_opdecode
    import ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_class
);

    logic [NUM_OPS-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_match
            assign w_hit[gi] = (i_opcode == OP_TABLE[gi]);
        end
    endgenerate

    assign o_class.rtype   = w_hit[IDX_RTYPE];
    assign o_class.imm     = w_hit[IDX_LI] | w_hit[IDX_ADDI] | w_hit[IDX_ANDI] | w_hit[IDX_ORI];
    assign o_class.load    = w_hit[IDX_LW];
    assign o_class.store   = w_hit[IDX_SW];
    assign o_class.cbranch = w_hit[IDX_BEQ] | w_hit[IDX_BNE];
    assign o_class.ubranch = w_hit[IDX_B];
    assign o_class.illegal = ~|w_hit;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM (FETCH/DECODE/EXEC/MEM/WB/BRANCH).
// Define ILLEGAL_OP_TRAP_EN to trap illegal opcodes and expose the Illegal output.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int IW  = 32,
    parameter int OPW = 6
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [IW-1:0] Instr,
    input  logic          Zero,
    output logic          IR_LdEn,
    output logic          PC_sel,
    output logic          PC_LdEn,
    output logic          RF_WrEn,
    output logic          RF_WrData_sel,
    output logic          ALU_Bin_sel,
    output logic [3:0]    ALU_func,
    output logic          MEM_WrEn
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic          Illegal
`endif
);

    state_t         r_state;
    state_t         w_state_next;
    logic [OPW-1:0] r_opcode;
    logic [3:0]     r_func;
    logic           r_zero_q;

    logic [OPW-1:0] w_instr_op;
    logic [OPW-1:0] w_dec_opcode;
    op_class_t      w_class;
    logic           w_unused_instr;

    assign w_instr_op     = Instr[IW-1 -: OPW];
    assign w_unused_instr = ^Instr[IW-OPW-1:4];

    // In DECODE the opcode is not latched yet, so classify straight from Instr.
    assign w_dec_opcode = (r_state == S_DECODE) ? w_instr_op : r_opcode;

    ctrl_opdecode u_opdecode (
        .i_opcode (w_dec_opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_RST;
            r_opcode <= '0;
            r_func   <= '0;
            r_zero_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_opcode <= w_instr_op;
                r_func   <= Instr[3:0];
            end
            if (r_state == S_EXEC) begin
                r_zero_q <= Zero;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RST:    w_state_next = S_FETCH;
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                if (w_class.ubranch) begin
                    w_state_next = S_BRANCH;
                end else if (w_class.illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    w_state_next = S_TRAP;
`else
                    w_state_next = S_WB_LITE;
`endif
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_class.load || w_class.store) begin
                    w_state_next = S_MEM;
                end else if (w_class.cbranch) begin
                    w_state_next = S_BRANCH;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM:     w_state_next = w_class.load ? S_WB : S_FETCH;
            S_WB:      w_state_next = S_FETCH;
            S_BRANCH:  w_state_next = S_FETCH;
            S_WB_LITE: w_state_next = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:    w_state_next = S_TRAP;
`endif
            default:   w_state_next = S_RST;
        endcase
    end

    always_comb begin
        IR_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        PC_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        MEM_WrEn      = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        Illegal       = 1'b0;
`endif
        case (r_state)
            S_FETCH: IR_LdEn = 1'b1;
            S_EXEC: begin
                if (w_class.rtype) begin
                    ALU_func = r_func;
                end else if (w_class.cbranch) begin
                    ALU_func = ALU_SUB;
                end else if (w_class.imm || w_class.load || w_class.store) begin
                    ALU_Bin_sel = 1'b1;
                    ALU_func    = imm_alu_func(r_opcode);
                end
            end
            S_MEM: begin
                if (w_class.store) begin
                    MEM_WrEn = 1'b1;
                    PC_LdEn  = 1'b1;
                end
            end
            S_WB: begin
                RF_WrEn       = 1'b1;
                RF_WrData_sel = w_class.load;
                PC_LdEn       = 1'b1;
            end
            S_BRANCH: begin
                PC_LdEn = 1'b1;
                PC_sel  = w_class.ubranch
                        | ((r_opcode == OP_BEQ) &  r_zero_q)
                        | ((r_opcode == OP_BNE) & ~r_zero_q);
            end
            S_WB_LITE: PC_LdEn = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:    Illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a per-instruction
// cycle-sequence model derived from the instruction semantics.
module tb_multicycle_control;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr = '0;
    logic        Zero = 1'b0;
    logic        IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, ALU_Bin_sel, MEM_WrEn;
    logic [3:0]  ALU_func;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        Illegal;
`endif

    multicycle_control #(.IW(32), .OPW(6)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .Zero          (Zero),
        .IR_LdEn       (IR_LdEn),
        .PC_sel        (PC_sel),
        .PC_LdEn       (PC_LdEn),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .ALU_Bin_sel   (ALU_Bin_sel),
        .ALU_func      (ALU_func),
        .MEM_WrEn      (MEM_WrEn)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .Illegal       (Illegal)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       ir;
        logic       pcsel;
        logic       pcld;
        logic       rfwr;
        logic       wdsel;
        logic       bsel;
        logic [3:0] func;
        logic       memwr;
        logic       ill;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t exp_q[$];

    logic [5:0] ops [10] = '{6'b100000, 6'b111000, 6'b110000, 6'b110010, 6'b110011,
                             6'b111111, 6'b000000, 6'b000001, 6'b001111, 6'b011111};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t observe();
        vec_t v;
        v.ir    = IR_LdEn;
        v.pcsel = PC_sel;
        v.pcld  = PC_LdEn;
        v.rfwr  = RF_WrEn;
        v.wdsel = RF_WrData_sel;
        v.bsel  = ALU_Bin_sel;
        v.func  = ALU_func;
        v.memwr = MEM_WrEn;
`ifdef ILLEGAL_OP_TRAP_EN
        v.ill   = Illegal;
`else
        v.ill   = 1'b0;
`endif
        return v;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected output vector for every cycle of one instruction, FETCH first.
    function automatic void build_expected(input logic [5:0] op, input logic [3:0] f, input logic z);
        vec_t v;
        exp_q.delete();
        v = '0; v.ir = 1'b1; exp_q.push_back(v);
        v = '0; exp_q.push_back(v);
        case (op)
            6'b111111: begin
                v = '0; v.pcld = 1'b1; v.pcsel = 1'b1; exp_q.push_back(v);
            end
            6'b100000, 6'b111000, 6'b110000, 6'b110010, 6'b110011: begin
                v = '0;
                v.bsel = (op != 6'b100000);
                v.func = (op == 6'b100000) ? f : (op == 6'b110010) ? 4'd2 :
                         (op == 6'b110011) ? 4'd3 : 4'd0;
                exp_q.push_back(v);
                v = '0; v.rfwr = 1'b1; v.pcld = 1'b1; exp_q.push_back(v);
            end
            6'b001111: begin
                v = '0; v.bsel = 1'b1; exp_q.push_back(v);
                v = '0; exp_q.push_back(v);
                v = '0; v.rfwr = 1'b1; v.wdsel = 1'b1; v.pcld = 1'b1; exp_q.push_back(v);
            end
            6'b011111: begin
                v = '0; v.bsel = 1'b1; exp_q.push_back(v);
                v = '0; v.memwr = 1'b1; v.pcld = 1'b1; exp_q.push_back(v);
            end
            6'b000000, 6'b000001: begin
                v = '0; v.func = 4'd1; exp_q.push_back(v);
                v = '0; v.pcld = 1'b1;
                v.pcsel = (op == 6'b000000) ? z : ~z;
                exp_q.push_back(v);
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                v = '0; v.ill = 1'b1;
                repeat (4) exp_q.push_back(v);
`else
                v = '0; v.pcld = 1'b1; exp_q.push_back(v);
`endif
            end
        endcase
    endfunction

    // Hold Reset for three edges (outputs must be idle), then release into FETCH.
    task automatic do_reset();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Instr = $urandom;
            Zero  = 1'($urandom);
            @(posedge Clk); #1;
            check_eq($sformatf("reset c%0d", i), 16'(observe()), 16'h0);
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    // Starts just after the edge that entered FETCH; abort_at >= 0 resets mid-instruction.
    task automatic run_instr(input logic [31:0] instr, input logic z_exec, input int abort_at);
        logic [4:0] zs;
        bit         need_reset;
        zs    = 5'($urandom);
        zs[2] = z_exec;
        build_expected(instr[31:26], instr[3:0], z_exec);
        need_reset = (abort_at >= 0);
`ifdef ILLEGAL_OP_TRAP_EN
        if (!is_legal(instr[31:26])) need_reset = 1'b1;
`endif
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == abort_at) break;
            Instr = instr;
            Zero  = zs[k];
            check_eq($sformatf("instr %h z=%0b c%0d", instr, z_exec, k), 16'(observe()), 16'(exp_q[k]));
            @(posedge Clk); #1;
        end
        if (need_reset) do_reset();
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] ins;
        int          ab;

        do_reset();
        run_instr(32'h3C00_0000, 1'b0, 2);
        run_instr(32'h8000_0001, 1'b0, -1);
        run_instr(32'h3C00_0000, 1'b1, -1);
        run_instr(32'h7C00_0000, 1'b0, -1);
        run_instr(32'h0000_0000, 1'b1, -1);
        run_instr(32'h0000_0000, 1'b0, -1);
        run_instr(32'h0400_0000, 1'b0, -1);
        run_instr(32'h0400_0000, 1'b1, -1);
        run_instr(32'hFC00_0000, 1'b0, -1);
        run_instr(32'h5400_0000, 1'b0, -1);
        for (int f = 4; f < 16; f++) run_instr(32'h8000_0000 | 32'(f), 1'($urandom), -1);

        for (int n = 0; n < 80; n++) begin
            int sel;
            sel = int'($urandom_range(0, 10));
            if (sel < 10) begin
                op = ops[sel];
            end else begin
                do op = 6'($urandom); while (is_legal(op));
            end
            ins = {op, 26'($urandom)};
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : -1;
            run_instr(ins, 1'($urandom), ab);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
